// File: rtl/md_if.sv
// ---------------------------------------------------------------------------
// md_if : issue/result bundle between the EX stage and the multiply/divide
//         unit. The pipeline side drives the issue fields and reads back
//         busy and the HI/LO registers.
// ---------------------------------------------------------------------------
`default_nettype none

interface md_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, md_op, md_a, md_b, cancel,
    input  busy, hi, lo
  );

  modport slave (
    input  start, md_op, md_a, md_b, cancel,
    output busy, hi, lo
  );
endinterface

`default_nettype wire

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : multi-cycle multiply/divide unit owning the HI/LO registers.
//           mult/multu/div/divu hold busy for a fixed number of cycles and
//           commit their result on the last edge; mthi/mtlo write at once.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic rst_n,
  md_if.slave  bus
);

  // Operation encoding on md_op; 0 and 7 are no-ops.
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  state;
  logic [0:0]  state_next;
  logic [3:0]  count;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  logic        busy_int;
  logic        accept;
  logic        issue_long;
  logic        issue_mthi;
  logic        issue_mtlo;
  logic [3:0]  load_value;
  logic        commit;

  // Multiplier datapath
  logic        mul_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;

  // Divider datapath
  logic        is_div;
  logic        div_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor_safe;
  logic        div_by_zero;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quotient;
  logic [31:0] remainder;

  // Result selection
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  // Busy reflects the countdown register directly, so reset clears it at once.
  assign busy_int = (count != 4'd0);

  // A new instruction is only taken when idle and not killed this cycle.
  assign accept = bus.start && !bus.cancel && !busy_int;

  // Decode the accepted instruction into long operations and HI/LO moves.
  always_comb begin
    issue_long = 1'b0;
    issue_mthi = 1'b0;
    issue_mtlo = 1'b0;
    load_value = MULT_LOAD;
    if (accept) begin
      case (bus.md_op)
        OP_MULT, OP_MULTU: begin
          issue_long = 1'b1;
          load_value = MULT_LOAD;
        end
        OP_DIV, OP_DIVU: begin
          issue_long = 1'b1;
          load_value = DIV_LOAD;
        end
        OP_MTHI: issue_mthi = 1'b1;
        OP_MTLO: issue_mtlo = 1'b1;
        default: ;
      endcase
    end
  end

  // State register of the issue/run control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: run from a long issue until the countdown reaches its last cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (issue_long) state_next = S_RUN;
      S_RUN:   if (count == 4'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode: the final running cycle is the one whose edge commits.
  always_comb begin
    commit = 1'b0;
    case (state)
      S_RUN:   commit = (count == 4'd1);
      default: commit = 1'b0;
    endcase
  end

  // Countdown: loaded on a long issue, then decremented to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (issue_long) begin
      count <= load_value;
    end else if (busy_int) begin
      count <= count - 4'd1;
    end
  end

  // Capture operands and opcode so the pipeline may move on during the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
    end else if (issue_long) begin
      op_q <= bus.md_op;
      a_q  <= bus.md_a;
      b_q  <= bus.md_b;
    end
  end

  // Single 64-bit multiplier; sign extension selects signed or unsigned product.
  always_comb begin
    mul_signed = (op_q == OP_MULT);
    mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
    mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
    product    = mul_a * mul_b;
  end

  // Divide on magnitudes and re-apply signs; this handles 0x80000000 / -1
  // without overflow since the magnitude 2^31 fits in 32 unsigned bits.
  always_comb begin
    is_div       = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_signed   = (op_q == OP_DIV);
    a_neg        = div_signed & a_q[31];
    b_neg        = div_signed & b_q[31];
    a_mag        = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag        = b_neg ? (~b_q + 32'd1) : b_q;
    div_by_zero  = (b_q == 32'd0);
    divisor_safe = div_by_zero ? 32'd1 : b_mag;
    quo_mag      = a_mag / divisor_safe;
    rem_mag      = a_mag % divisor_safe;
    quotient     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
    remainder    = a_neg ? (~rem_mag + 32'd1) : rem_mag;
  end

  // Pick the committed value; a zero divisor leaves HI/LO untouched.
  always_comb begin
    res_hi = product[63:32];
    res_lo = product[31:0];
    res_we = 1'b1;
    if (is_div) begin
      res_hi = remainder;
      res_lo = quotient;
      res_we = !div_by_zero;
    end
  end

  // HI/LO: immediate moves when idle, long results on the final edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (issue_mthi) hi_q <= bus.md_a;
      if (issue_mtlo) lo_q <= bus.md_a;
      if (commit && res_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy = busy_int;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit : directed and random stimulus for md_unit, checked every
//              cycle against a cycle-count reference model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  // Reference model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_left;
  logic [31:0] m_res_hi;
  logic [31:0] m_res_lo;
  logic        m_wr;

  md_if bus ();

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // Advance the model by one rising edge with the given issue inputs.
  task automatic model_edge(input logic s, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic c);
    logic [63:0] p;
    logic [31:0] q, r;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_res_hi;
        m_lo = m_res_lo;
      end
    end else if (s && !c) begin
      case (op)
        3'd1, 3'd2: begin
          p        = ref_mul(op == 3'd1, a, b);
          m_res_hi = p[63:32];
          m_res_lo = p[31:0];
          m_wr     = 1'b1;
          m_left   = MULT_N;
        end
        3'd3, 3'd4: begin
          m_wr = (b != 32'd0);
          if (m_wr) begin
            ref_div(op == 3'd3, a, b, q, r);
            m_res_lo = q;
            m_res_hi = r;
          end
          m_left = DIV_N;
        end
        3'd5: m_hi = a;
        3'd6: m_lo = a;
        default: ;
      endcase
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, {31'd0, (m_left != 0)});
    chk({tag, "_hi"}, bus.hi, m_hi);
    chk({tag, "_lo"}, bus.lo, m_lo);
  endtask

  task automatic step(input string tag, input logic s, input logic [2:0] op,
                      input logic [31:0] a, input logic [31:0] b, input logic c);
    @(negedge clk);
    bus.start  = s;
    bus.md_op  = op;
    bus.md_a   = a;
    bus.md_b   = b;
    bus.cancel = c;
    @(posedge clk);
    model_edge(s, op, a, b, c);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    n_checks   = 0;
    n_err      = 0;
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    m_left     = 0;
    m_res_hi   = 32'd0;
    m_res_lo   = 32'd0;
    m_wr       = 1'b0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.md_op  = 3'd0;
    bus.md_a   = 32'd0;
    bus.md_b   = 32'd0;
    bus.cancel = 1'b0;

    // Reset state, observed before any clock edge.
    #2;
    check_all("reset");
    rst_n = 1'b1;

    // Signed and unsigned multiply of -2 by 3.
    step("mult_issue", 1'b1, 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle("mult_run", MULT_N);
    chk("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
    step("multu_issue", 1'b1, 3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0);
    idle("multu_run", MULT_N);
    chk("multu_hi_const", bus.hi, 32'h0000_0002);
    chk("multu_lo_const", bus.lo, 32'hFFFF_FFFA);

    // Signed divide -7 / 2.
    step("div_issue", 1'b1, 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    idle("div_run", DIV_N);
    chk("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    chk("div_hi_const", bus.hi, 32'hFFFF_FFFF);

    // Divide overflow corner.
    step("divovf_issue", 1'b1, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle("divovf_run", DIV_N);
    chk("divovf_lo_const", bus.lo, 32'h8000_0000);
    chk("divovf_hi_const", bus.hi, 32'h0000_0000);

    // Divide by zero keeps HI/LO.
    step("mthi_pre", 1'b1, 3'd5, 32'h1234_5678, 32'd0, 1'b0);
    step("mtlo_pre", 1'b1, 3'd6, 32'h1234_5678, 32'd0, 1'b0);
    step("divz_issue", 1'b1, 3'd4, 32'd7, 32'd0, 1'b0);
    idle("divz_run", DIV_N);
    chk("divz_hi_const", bus.hi, 32'h1234_5678);
    chk("divz_lo_const", bus.lo, 32'h1234_5678);

    // Immediate moves.
    step("mthi", 1'b1, 3'd5, 32'hA5A5_A5A5, 32'd0, 1'b0);
    chk("mthi_const", bus.hi, 32'hA5A5_A5A5);
    step("mtlo", 1'b1, 3'd6, 32'hA5A5_A5A5, 32'd0, 1'b0);
    chk("mtlo_const", bus.lo, 32'hA5A5_A5A5);

    // Start while busy is ignored.
    step("ovl_mult", 1'b1, 3'd1, 32'd1000, 32'd7, 1'b0);
    idle("ovl_c1", 1);
    step("ovl_div", 1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
    idle("ovl_run", MULT_N - 2);
    chk("ovl_lo_const", bus.lo, 32'd7000);
    chk("ovl_busy_const", {31'd0, bus.busy}, 32'd0);

    // Cancel suppresses issue; cancel during a run does not abort it.
    step("cancel_issue", 1'b1, 3'd1, 32'd9, 32'd9, 1'b1);
    step("cancel_mthi", 1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
    step("late_issue", 1'b1, 3'd2, 32'd11, 32'd13, 1'b0);
    step("late_cancel", 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
    idle("late_run", MULT_N - 1);
    chk("late_lo_const", bus.lo, 32'd143);

    // Reserved and none opcodes are no-ops.
    step("op0", 1'b1, 3'd0, 32'h1111_1111, 32'd5, 1'b0);
    step("op7", 1'b1, 3'd7, 32'h2222_2222, 32'd5, 1'b0);

    // Reset in cycle 3 of a divide, between edges.
    step("rst_div", 1'b1, 3'd3, 32'd50, 32'd7, 1'b0);
    idle("rst_c", 2);
    #2;
    rst_n = 1'b0;
    #1;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    m_left = 0;
    check_all("rst_async");
    @(posedge clk);
    #1;
    check_all("rst_hold");
    #2;
    rst_n = 1'b1;
    step("post_rst_mtlo", 1'b1, 3'd6, 32'h0000_0055, 32'd0, 1'b0);
    idle("post_rst", DIV_N);
    chk("post_rst_hi_const", bus.hi, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 9) < 4), 3'($urandom_range(0, 7)),
           rand_operand(), rand_operand(), ($urandom_range(0, 9) == 0));
    end
    idle("drain", DIV_N + 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 MULT_CYCLES, 5, Busy duration in cycles for mult/multu (legal range 1-15).
REQ-002 DIV_CYCLES, 10, Busy duration in cycles for div/divu (legal range 1-15).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 Start  in  1  issue strobe for the EX-stage multiply/divide-class instruction this cycle.
REQ-006 MdOp  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no-op).
REQ-007 MdA  in  32  rs operand (dividend / multiplicand / mthi-mtlo source).
REQ-008 MdB  in  32  rt operand (divisor / multiplier).
REQ-009 Cancel  in  1  exception/interrupt kill for the instruction issuing this cycle.
REQ-010 Busy  out  1  operation in progress; ID-stage stall logic consumes it.
REQ-011 HI  out  32  architectural HI register.
REQ-012 LO  out  32  architectural LO register; HI/LO feed EXMdRes for mfhi/mflo.

Function
REQ-013 An issue SHALL occur at a rising edge when Start=1, Cancel=0, Busy=0 and MdOp is 1-6; otherwise the edge SHALL leave HI, LO and Busy state unchanged (except countdown, REQ-016).
REQ-014 mult/multu/div/divu issue SHALL latch MdA, MdB and MdOp into internal registers and load a down-counter with MULT_CYCLES (1,2) or DIV_CYCLES (3,4).
REQ-015 Busy SHALL equal (counter != 0), registered; Start in cycle 0 -> Busy=1 in cycles 1..N -> Busy=0 in cycle N+1.
REQ-016 Counter SHALL decrement by 1 each edge while nonzero; at the edge where it goes 1->0 the result SHALL be written to HI/LO, visible from cycle N+1.
REQ-017 HI/LO SHALL hold previous values throughout cycles 1..N.
REQ-018 mult: {HI,LO} = signed 32x32 -> 64-bit product; multu: unsigned product.
REQ-019 div: LO = quotient truncated toward zero, HI = remainder with sign of dividend; divu: unsigned quotient/remainder.
REQ-020 div with MdA=0x80000000, MdB=0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-021 div/divu with MdB=0 SHALL still assert Busy for DIV_CYCLES but leave HI and LO unchanged at completion.
REQ-022 mthi/mtlo issue SHALL write MdA into HI/LO at that same edge, with no Busy assertion.
REQ-023 Start=1 while Busy=1 SHALL be ignored (no restart, no HI/LO write); Cancel=1 with Start=1 SHALL suppress the issue entirely.
REQ-024 Cancel while Busy=1 and Start=0 SHALL NOT abort the in-flight operation; a started operation always commits.
REQ-025 MdOp 0 or 7 with Start=1 SHALL be a no-op.
REQ-026 Result computation timing is free (combinational on latched operands or iterative) provided REQ-015/016 cycle behaviour is exact.

Reset
REQ-027 reset=0 SHALL immediately, without waiting for clk, clear HI, LO, counter, latched operands/op and Busy to 0.
REQ-028 reset asserted mid-operation SHALL discard the operation; after release Busy=0, HI=LO=0 and no late write occurs.
REQ-029 The first rising edge after reset release SHALL accept an issue normally.

Verification
REQ-030 mult MdA=0xFFFFFFFE, MdB=3 -> Busy high cycles 1-5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 div MdA=0xFFFFFFF9 (-7), MdB=2 -> Busy cycles 1-10; cycle 11 LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu MdA=7, MdB=0 with HI=LO=0x12345678 beforehand -> Busy 10 cycles, HI/LO stay 0x12345678.
REQ-032 mthi MdA=0xA5A5A5A5 -> HI=0xA5A5A5A5 next cycle, Busy never asserts; mtlo likewise on LO.
REQ-033 mult issued, then Start+div in cycle 2 -> div ignored; cycle 6 holds mult result, Busy=0; Start+mult with Cancel=1 -> HI/LO and Busy unchanged.
REQ-034 reset pulled low in cycle 3 of a div, between edges -> HI, LO, Busy read 0 before next edge; no write at cycle 11.
